// File: rtl/seq_issue_ctrl.sv
// seq_issue_ctrl: program buffer that issues its instructions to the core one at a time.
// Optional single-step mode is enabled by defining SEQ_ISSUE_STEP_EN.
module seq_issue_ctrl #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_vld,
   input  logic [7:0]  load_wd,
   output logic        load_rdy,
   input  logic        clr,
   input  logic        run,
   input  logic        step,
   input  logic        abort,
   input  logic        core_busy,
   output logic        inst_vld,
   output logic [7:0]  inst_wd,
   output logic        running,
   output logic        done,
   output logic        ovf,
   output logic [AW:0] prog_cnt,
   output logic [AW:0] pc
);

   typedef enum logic [1:0] {
      S_IDLE        = 2'd0,
      S_ISSUE       = 2'd1,
      S_WAIT_SETTLE = 2'd2,
      S_WAIT_IDLE   = 2'd3
   } state_t;

   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW:0] LP_ONE   = (AW+1)'(1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_buf [DEPTH];
   logic [AW:0] r_prog_cnt;
   logic [AW:0] w_cnt_nxt;
   logic [AW:0] r_pc;
   logic [AW:0] w_pc_nxt;
   logic        r_ovf;
   logic        w_ovf_nxt;
   logic [7:0]  r_inst_wd;
   logic [7:0]  w_wd_nxt;
   logic        r_run_pend;
   logic        w_pend_nxt;
   logic        w_run;
   logic        w_full;
   logic        w_wr_en;
`ifdef SEQ_ISSUE_STEP_EN
   logic        r_sstep;
   logic        w_sstep_nxt;
`else
   logic        w_unused_step;

   assign w_unused_step = step;
`endif

   // A run that collides with a load/clear is replayed against the new count
   assign w_run  = run | r_run_pend;
   assign w_full = (r_prog_cnt == LP_DEPTH);

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_cnt_nxt   = r_prog_cnt;
      w_ovf_nxt   = r_ovf;
      w_wd_nxt    = r_inst_wd;
      w_pend_nxt  = 1'b0;
      w_wr_en     = 1'b0;
`ifdef SEQ_ISSUE_STEP_EN
      w_sstep_nxt = r_sstep;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (clr) begin
               w_cnt_nxt = '0;
               w_pc_nxt  = '0;
               w_ovf_nxt = 1'b0;
            end else if (load_vld) begin
               if (w_full) begin
                  w_ovf_nxt = 1'b1;
               end else begin
                  w_wr_en   = 1'b1;
                  w_cnt_nxt = r_prog_cnt + LP_ONE;
               end
            end
            if (clr || load_vld) begin
               w_pend_nxt = w_run;
            end else if (w_run) begin
               if (r_prog_cnt != '0) begin
                  w_state_nxt = S_ISSUE;
                  w_pc_nxt    = '0;
                  w_wd_nxt    = r_buf[0];
`ifdef SEQ_ISSUE_STEP_EN
                  w_sstep_nxt = 1'b0;
`endif
               end
            end
`ifdef SEQ_ISSUE_STEP_EN
            else if (step && (r_pc < r_prog_cnt)) begin
               w_state_nxt = S_ISSUE;
               w_wd_nxt    = r_buf[r_pc[AW-1:0]];
               w_sstep_nxt = 1'b1;
            end
`endif
         end
         S_ISSUE: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_pc_nxt    = '0;
            end else begin
               w_state_nxt = S_WAIT_SETTLE;
               w_pc_nxt    = r_pc + LP_ONE;
            end
         end
         S_WAIT_SETTLE: begin
            w_state_nxt = S_WAIT_IDLE;
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_pc_nxt    = '0;
            end
         end
         S_WAIT_IDLE: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_pc_nxt    = '0;
            end else if (!core_busy) begin
               if (r_pc == r_prog_cnt) begin
                  w_state_nxt = S_IDLE;
`ifdef SEQ_ISSUE_STEP_EN
                  if (!r_sstep) w_pc_nxt = '0;
`else
                  w_pc_nxt = '0;
`endif
               end
`ifdef SEQ_ISSUE_STEP_EN
               else if (r_sstep) begin
                  w_state_nxt = S_IDLE;
               end
`endif
               else begin
                  w_state_nxt = S_ISSUE;
                  w_wd_nxt    = r_buf[r_pc[AW-1:0]];
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_prog_cnt <= '0;
         r_pc       <= '0;
         r_ovf      <= 1'b0;
         r_inst_wd  <= '0;
         r_run_pend <= 1'b0;
`ifdef SEQ_ISSUE_STEP_EN
         r_sstep    <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_prog_cnt <= w_cnt_nxt;
         r_pc       <= w_pc_nxt;
         r_ovf      <= w_ovf_nxt;
         r_inst_wd  <= w_wd_nxt;
         r_run_pend <= w_pend_nxt;
`ifdef SEQ_ISSUE_STEP_EN
         r_sstep    <= w_sstep_nxt;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) r_buf[r_prog_cnt[AW-1:0]] <= load_wd;
   end

   assign load_rdy = (r_state == S_IDLE) && !w_full;
   assign inst_vld = (r_state == S_ISSUE);
   assign inst_wd  = r_inst_wd;
   assign running  = (r_state != S_IDLE);
   assign done     = (r_state == S_WAIT_IDLE) && !core_busy && !abort &&
                     (r_pc == r_prog_cnt);
   assign ovf      = r_ovf;
   assign prog_cnt = r_prog_cnt;
   assign pc       = r_pc;

endmodule

// File: tb/tb_seq_issue_ctrl.sv
// Scoreboard bench for seq_issue_ctrl: a program model predicts the issue/done
// stream, and a monitor pops and compares every observed event.
module tb_seq_issue_ctrl;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_vld;
   logic [7:0]  load_wd;
   logic        load_rdy;
   logic        clr;
   logic        run;
   logic        step;
   logic        abort;
   logic        core_busy;
   logic        inst_vld;
   logic [7:0]  inst_wd;
   logic        running;
   logic        done;
   logic        ovf;
   logic [AW:0] prog_cnt;
   logic [AW:0] pc;

   always #5 clk = ~clk;

   seq_issue_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .load_vld(load_vld), .load_wd(load_wd), .load_rdy(load_rdy),
      .clr(clr), .run(run), .step(step), .abort(abort),
      .core_busy(core_busy),
      .inst_vld(inst_vld), .inst_wd(inst_wd),
      .running(running), .done(done), .ovf(ovf),
      .prog_cnt(prog_cnt), .pc(pc)
   );

   typedef struct packed {
      logic       dn;
      logic [7:0] wd;
   } ev_t;

   ev_t        sbq[$];
   ev_t        mon_e;
   logic [7:0] mprog[$];
   int         mpc;
   int         n_chk = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         t_run = 0;
   int         busy_mode = 0;
   int         busy_fall = 0;
   int         b_lat;
   int         b_len;
   int         last_iss = -100;
   int         iss_cyc[$];
   int         done_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   // Core model: random or SEND-triggered busy windows after an issue
   initial begin
      core_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (inst_vld && !rst) begin
            if (busy_mode == 1) begin
               b_lat = $urandom_range(0, 1);
               b_len = $urandom_range(0, 5);
               repeat (b_lat) @(negedge clk);
               if (b_len > 0) begin
                  core_busy = 1'b1;
                  repeat (b_len) @(negedge clk);
                  core_busy = 1'b0;
               end
            end else if (busy_mode == 2 && inst_wd == 8'hC0) begin
               core_busy = 1'b1;
               repeat (200) @(negedge clk);
               core_busy = 1'b0;
               busy_fall = cyc;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            if (inst_vld) begin
               iss_cyc.push_back(cyc);
               n_chk++;
               if (cyc - last_iss < 3) begin
                  n_fail++;
                  $display("FAIL issue_gap: got %0d cycles, required >=3",
                           cyc - last_iss);
               end
               last_iss = cyc;
               n_chk++;
               if (sbq.size() == 0) begin
                  n_fail++;
                  $display("FAIL issue_extra: got word %02h, required none",
                           inst_wd);
               end else begin
                  mon_e = sbq.pop_front();
                  if (mon_e.dn || mon_e.wd !== inst_wd) begin
                     n_fail++;
                     $display("FAIL issue_word: got %02h, required %s %02h",
                              inst_wd, mon_e.dn ? "done" : "issue", mon_e.wd);
                  end
               end
            end
            if (done) begin
               done_cyc.push_back(cyc);
               n_chk++;
               if (sbq.size() == 0) begin
                  n_fail++;
                  $display("FAIL done_extra: got done, required none");
               end else begin
                  mon_e = sbq.pop_front();
                  if (!mon_e.dn) begin
                     n_fail++;
                     $display("FAIL done_early: got done, required issue %02h",
                              mon_e.wd);
                  end
               end
            end
            n_chk++;
            if (pc > prog_cnt) begin
               n_fail++;
               $display("FAIL pc_bound: got pc %0d, required <= %0d",
                        pc, prog_cnt);
            end
         end
      end
   end

   task automatic do_load(input logic [7:0] w);
      @(negedge clk);
      load_vld = 1'b1;
      load_wd  = w;
      @(negedge clk);
      load_vld = 1'b0;
      if (mprog.size() < DEPTH) mprog.push_back(w);
   endtask

   task automatic do_clr();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      mprog.delete();
      mpc = 0;
   endtask

   task automatic pulse_run(input logic with_step, input int n_iss,
                            input logic with_done);
      ev_t e;
      iss_cyc.delete();
      done_cyc.delete();
      for (int i = 0; i < n_iss; i++) begin
         e.dn = 1'b0;
         e.wd = mprog[i];
         sbq.push_back(e);
      end
      if (with_done) begin
         e.dn = 1'b1;
         e.wd = 8'h00;
         sbq.push_back(e);
      end
      @(negedge clk);
      run   = 1'b1;
      step  = with_step;
      t_run = cyc;
      @(negedge clk);
      run  = 1'b0;
      step = 1'b0;
      mpc  = 0;
   endtask

   task automatic wait_sb(input string nm, input int bound);
      int k = 0;
      while (sbq.size() != 0 && k < bound) begin
         @(negedge clk);
         #2;
         k++;
      end
      check({nm, "_drained"}, 32'(sbq.size()), 32'd0);
      sbq.delete();
      @(negedge clk);
      #2;
      check({nm, "_running"}, 32'(running), 32'd0);
   endtask

   initial begin
      int n;
      int exp_off[4];
      exp_off = '{1, 4, 7, 10};
      rst = 1'b0; load_vld = 1'b0; load_wd = 8'h00; clr = 1'b0;
      run = 1'b0; step = 1'b0; abort = 1'b0; mpc = 0;
      #2 rst = 1'b1;
      #10;
      check("rst_inst_vld", 32'(inst_vld), 32'd0);
      check("rst_inst_wd", 32'(inst_wd), 32'd0);
      check("rst_running", 32'(running), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_prog_cnt", 32'(prog_cnt), 32'd0);
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_load_rdy", 32'(load_rdy), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // Multiply program, core never busy
      do_load(8'h01); do_load(8'h12); do_load(8'h93); do_load(8'hC0);
      #2 check("mult_prog_cnt", 32'(prog_cnt), 32'd4);
      pulse_run(1'b0, 4, 1'b1);
      wait_sb("mult", 50);
      check("mult_n_issue", 32'(iss_cyc.size()), 32'd4);
      for (int i = 0; i < iss_cyc.size() && i < 4; i++)
         check("mult_issue_off", 32'(iss_cyc[i] - t_run), 32'(exp_off[i]));
      check("mult_n_done", 32'(done_cyc.size()), 32'd1);
      if (done_cyc.size() > 0)
         check("mult_done_off", 32'(done_cyc[0] - t_run), 32'd12);
      check("mult_pc", 32'(pc), 32'd0);

      // Core stays busy 200 cycles after SEND
      busy_mode = 2;
      pulse_run(1'b0, 4, 1'b1);
      wait_sb("stall", 400);
      busy_mode = 0;
      check("stall_n_issue", 32'(iss_cyc.size()), 32'd4);
      check("stall_n_done", 32'(done_cyc.size()), 32'd1);
      if (done_cyc.size() > 0) begin
         check("stall_done_at_fall", 32'(done_cyc[0]), 32'(busy_fall));
         check("stall_done_late", 32'(done_cyc[0] - t_run > 200), 32'd1);
      end

      // Overflow and clear
      do_clr();
      for (int i = 0; i < DEPTH; i++) do_load(8'($urandom));
      #2;
      check("ovf_cnt_full", 32'(prog_cnt), 32'(DEPTH));
      check("ovf_rdy_full", 32'(load_rdy), 32'd0);
      check("ovf_not_yet", 32'(ovf), 32'd0);
      do_load(8'hEE);
      #2;
      check("ovf_set", 32'(ovf), 32'd1);
      check("ovf_cnt_hold", 32'(prog_cnt), 32'(DEPTH));
      busy_mode = 1;
      pulse_run(1'b0, DEPTH, 1'b1);
      wait_sb("full_run", 600);
      busy_mode = 0;
      do_clr();
      #2;
      check("clr_cnt", 32'(prog_cnt), 32'd0);
      check("clr_ovf", 32'(ovf), 32'd0);
      check("clr_rdy", 32'(load_rdy), 32'd1);
      @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      #2 check("empty_run_ignored", 32'(running), 32'd0);

      // Abort in WAIT_IDLE after the 2nd of 4 words
      for (int i = 0; i < 4; i++) do_load(8'($urandom));
      pulse_run(1'b0, 2, 1'b0);
      repeat (5) @(negedge clk);
      abort = 1'b1;
      #2;
      check("abort_pre_running", 32'(running), 32'd1);
      check("abort_pre_pc", 32'(pc), 32'd2);
      @(negedge clk);
      abort = 1'b0;
      #2;
      check("abort_idle", 32'(running), 32'd0);
      check("abort_pc", 32'(pc), 32'd0);
      check("abort_sb", 32'(sbq.size()), 32'd0);
      check("abort_no_done", 32'(done_cyc.size()), 32'd0);
      pulse_run(1'b0, 4, 1'b1);
      wait_sb("rerun", 60);

      // Single step
      do_clr();
      for (int i = 0; i < 3; i++) do_load(8'($urandom));
`ifdef SEQ_ISSUE_STEP_EN
      for (int s = 0; s < 3; s++) begin
         ev_t e;
         e.dn = 1'b0;
         e.wd = mprog[mpc];
         sbq.push_back(e);
         mpc++;
         if (mpc == mprog.size()) begin
            e.dn = 1'b1;
            e.wd = 8'h00;
            sbq.push_back(e);
         end
         @(negedge clk);
         step = 1'b1;
         @(negedge clk);
         step = 1'b0;
         repeat (4) @(negedge clk);
         #2;
         check("step_pc", 32'(pc), 32'(mpc));
         check("step_idle", 32'(running), 32'd0);
         check("step_sb", 32'(sbq.size()), 32'd0);
      end
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      check("step_end_pc", 32'(pc), 32'd3);
      check("step_end_idle", 32'(running), 32'd0);
`else
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      check("nostep_idle", 32'(running), 32'd0);
      check("nostep_pc", 32'(pc), 32'd0);
`endif
      pulse_run(1'b1, 3, 1'b1);
      wait_sb("run_over_step", 60);
      check("run_over_step_pc", 32'(pc), 32'd0);

      // Random programs with random core busy windows
      busy_mode = 1;
      for (int r = 0; r < 12; r++) begin
         do_clr();
         n = $urandom_range(1, DEPTH);
         for (int i = 0; i < n; i++) do_load(8'($urandom));
         #2 check("rand_cnt", 32'(prog_cnt), 32'(mprog.size()));
         pulse_run(1'b0, n, 1'b1);
         wait_sb("rand", 40 * n + 20);
         check("rand_pc", 32'(pc), 32'd0);
      end
      busy_mode = 0;

      // Asynchronous reset during ISSUE
      do_clr();
      for (int i = 0; i < 3; i++) do_load(8'($urandom));
      pulse_run(1'b0, 1, 1'b0);
      #2 check("arst_in_issue", 32'(inst_vld), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("arst_inst_vld", 32'(inst_vld), 32'd0);
      check("arst_inst_wd", 32'(inst_wd), 32'd0);
      check("arst_running", 32'(running), 32'd0);
      check("arst_prog_cnt", 32'(prog_cnt), 32'd0);
      check("arst_pc", 32'(pc), 32'd0);
      check("arst_load_rdy", 32'(load_rdy), 32'd1);
      check("arst_sb", 32'(sbq.size()), 32'd0);
      sbq.delete();
      mprog.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
